// File: rtl/mips_decode_reg.sv
// Fetch-to-decode pipeline register: 2-entry skid buffer with registered field decode.
// Optional statistics counters are built only when MIPS_DECODE_STATS_EN is defined.
module mips_decode_reg #(
  parameter int INSTR_W = 32,
  parameter int CONST_W = 15,
  parameter int STAT_W  = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  input  logic               in_valid,
  input  logic [INSTR_W-1:0] in_instr,
  output logic               in_ready,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [6:0]         out_opcode,
  output logic [4:0]         out_rd,
  output logic [4:0]         out_rs,
  output logic [4:0]         out_rt,
  output logic [CONST_W-1:0] out_const,
  output logic               out_const_sign,
  output logic               out_use_const,
  output logic [STAT_W-1:0]  stat_accepted,
  output logic [STAT_W-1:0]  stat_stalls
);

  logic               main_valid_q, main_valid_d;
  logic [INSTR_W-1:0] main_instr_q, main_instr_d;
  logic               skid_valid_q, skid_valid_d;
  logic [INSTR_W-1:0] skid_instr_q, skid_instr_d;
  logic               accept;
  logic               issue;

  // in_ready depends only on skid occupancy, so it never combinationally follows out_ready.
  assign in_ready  = ~skid_valid_q;
  assign out_valid = main_valid_q;
  assign accept    = in_valid & in_ready;
  assign issue     = out_valid & out_ready;

  always_comb begin
    main_valid_d = main_valid_q;
    main_instr_d = main_instr_q;
    skid_valid_d = skid_valid_q;
    skid_instr_d = skid_instr_q;
    if (flush) begin
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
    end else if (issue) begin
      if (skid_valid_q) begin
        main_valid_d = 1'b1;
        main_instr_d = skid_instr_q;
        skid_valid_d = accept;
        if (accept) begin
          skid_instr_d = in_instr;
        end
      end else begin
        main_valid_d = accept;
        if (accept) begin
          main_instr_d = in_instr;
        end
      end
    end else if (accept) begin
      if (main_valid_q) begin
        skid_valid_d = 1'b1;
        skid_instr_d = in_instr;
      end else begin
        main_valid_d = 1'b1;
        main_instr_d = in_instr;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      main_instr_q <= '0;
      skid_valid_q <= 1'b0;
      skid_instr_q <= '0;
    end else begin
      main_valid_q <= main_valid_d;
      main_instr_q <= main_instr_d;
      skid_valid_q <= skid_valid_d;
      skid_instr_q <= skid_instr_d;
    end
  end

  // Pure bit slicing; extension to 32 bits happens in the constant extender.
  assign out_opcode     = main_instr_q[31:25];
  assign out_rd         = main_instr_q[24:20];
  assign out_rs         = main_instr_q[19:15];
  assign out_rt         = main_instr_q[14:10];
  assign out_const      = main_instr_q[CONST_W-1:0];
  assign out_use_const  = main_instr_q[31];
  assign out_const_sign = main_instr_q[31] & ~main_instr_q[30];

`ifdef MIPS_DECODE_STATS_EN
  logic [STAT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic [STAT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Counters saturate at all-ones and ignore flush; only accepts in a flush cycle are excluded.
  always_comb begin
    acc_cnt_d   = acc_cnt_q;
    stall_cnt_d = stall_cnt_q;
    if (accept && !flush && (acc_cnt_q != {STAT_W{1'b1}})) begin
      acc_cnt_d = acc_cnt_q + 1'b1;
    end
    if (out_valid && !out_ready && (stall_cnt_q != {STAT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_cnt_q   <= '0;
      stall_cnt_q <= '0;
    end else begin
      acc_cnt_q   <= acc_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stat_accepted = acc_cnt_q;
  assign stat_stalls   = stall_cnt_q;
`else
  assign stat_accepted = '0;
  assign stat_stalls   = '0;
`endif

endmodule

// File: tb/tb_mips_decode_reg.sv
// Testbench for mips_decode_reg: decode vector table, FIFO scoreboard, back-pressure, flush, reset, stats.
module tb_mips_decode_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs;
  logic [4:0]  out_rt;
  logic [14:0] out_const;
  logic        out_const_sign;
  logic        out_use_const;
  logic [15:0] stat_accepted;
  logic [15:0] stat_stalls;

  int n_cmp = 0;
  int n_err = 0;
  int n_issued = 0;
  logic [31:0] sb_q[$];

  mips_decode_reg dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_instr(in_instr), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs(out_rs), .out_rt(out_rt),
    .out_const(out_const), .out_const_sign(out_const_sign), .out_use_const(out_use_const),
    .stat_accepted(stat_accepted), .stat_stalls(stat_stalls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: mid-cycle sampling of handshakes; pops on issue, pushes on accept.
  always @(negedge clk) begin
    logic [31:0] w;
    if (rst) begin
      sb_q.delete();
    end else begin
      chk("out_valid_vs_model", {31'd0, out_valid}, {31'd0, sb_q.size() != 0});
      chk("in_ready_vs_model", {31'd0, in_ready}, {31'd0, sb_q.size() < 2});
      if (out_valid && out_ready && sb_q.size() != 0) begin
        w = sb_q.pop_front();
        n_issued++;
        chk("issued_word", {out_opcode, out_rd, out_rs, out_const}, w);
        chk("issued_rt", {27'd0, out_rt}, {27'd0, w[14:10]});
        chk("issued_flags", {30'd0, out_const_sign, out_use_const}, {30'd0, w[31] & ~w[30], w[31]});
      end
      if (flush) sb_q.delete();
      else if (in_valid && in_ready) sb_q.push_back(in_instr);
    end
    $display("cyc t=%0t rst=%0b fl=%0b iv=%0b ir=%0b in=%08h ov=%0b or=%0b op=%02h rd=%0d rs=%0d rt=%0d c=%04h s=%0b u=%0b",
             $time, rst, flush, in_valid, in_ready, in_instr, out_valid, out_ready,
             out_opcode, out_rd, out_rs, out_rt, out_const, out_const_sign, out_use_const);
  end

  typedef struct {
    logic [31:0] instr;
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [14:0] cst;
    logic        sign;
    logic        use_c;
  } vec_t;

  vec_t vecs[5];

  task automatic do_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_instr = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    chk({tag, "_in_ready"}, {31'd0, in_ready}, 32'd1);
    chk({tag, "_fields"}, {out_opcode, out_rd, out_rs, out_const}, 32'd0);
    chk({tag, "_rt_flags"}, {25'd0, out_rt, out_const_sign, out_use_const}, 32'd0);
    chk({tag, "_stats"}, {stat_accepted, stat_stalls}, 32'd0);
  endtask

  initial begin
    int base;
    vecs[0] = '{32'h8032FFFF, 7'h40, 5'd3,  5'd5,  5'd31, 15'h7FFF, 1'b1, 1'b1};
    vecs[1] = '{32'hC0000005, 7'h60, 5'd0,  5'd0,  5'd0,  15'h0005, 1'b0, 1'b1};
    vecs[2] = '{32'h00000C00, 7'h00, 5'd0,  5'd0,  5'd3,  15'h0C00, 1'b0, 1'b0};
    vecs[3] = '{32'h7FFFFFFF, 7'h3F, 5'd31, 5'd31, 5'd31, 15'h7FFF, 1'b0, 1'b0};
    vecs[4] = '{32'hA5A5A5A5, 7'h52, 5'd26, 5'd11, 5'd9,  15'h25A5, 1'b1, 1'b1};

    do_reset();
    chk_reset_state("reset");

    // Decode table: one word each, held one extra cycle to check stability, then issued.
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_instr = vecs[i].instr; out_ready = 1'b0;
      step();
      in_valid = 1'b0;
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("vec%0d_valid", i), {31'd0, out_valid}, 32'd1);
        chk($sformatf("vec%0d_opcode", i), {25'd0, out_opcode}, {25'd0, vecs[i].op});
        chk($sformatf("vec%0d_rd_rs_rt", i), {17'd0, out_rd, out_rs, out_rt}, {17'd0, vecs[i].rd, vecs[i].rs, vecs[i].rt});
        chk($sformatf("vec%0d_const", i), {17'd0, out_const}, {17'd0, vecs[i].cst});
        chk($sformatf("vec%0d_flags", i), {30'd0, out_const_sign, out_use_const}, {30'd0, vecs[i].sign, vecs[i].use_c});
        step();
      end
      out_ready = 1'b1;
      step();
      out_ready = 1'b0;
      chk($sformatf("vec%0d_drained", i), {31'd0, out_valid}, 32'd0);
    end

    // Back-pressure: two words fill the buffer, the third waits for in_ready.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h11111111;
    step();
    chk("bp_ready_after_1st", {31'd0, in_ready}, 32'd1);
    in_instr = 32'h22222222;
    step();
    chk("bp_ready_after_2nd", {31'd0, in_ready}, 32'd0);
    in_instr = 32'h33333333;
    step();
    step();
    chk("bp_held_ready", {31'd0, in_ready}, 32'd0);
    chk("bp_head_stable", {25'd0, out_opcode}, 32'h08);
    base = n_issued;
    out_ready = 1'b1;
    step();
    step();
    in_valid = 1'b0;
    step();
    chk("bp_issued_count", n_issued - base, 32'd3);
    step();

    // Streaming: ten back-to-back words with no stall.
    base = n_issued;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'b1; in_instr = 32'h00001000 + i;
      step();
      chk($sformatf("stream_in_ready%0d", i), {31'd0, in_ready}, 32'd1);
    end
    in_valid = 1'b0;
    step();
    chk("stream_issued_count", n_issued - base, 32'd10);
    step();

    // Flush with a full buffer: the word offered in the flush cycle must vanish.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hAAAA0001;
    step();
    in_instr = 32'hAAAA0002;
    step();
    in_instr = 32'hDEADBEEF; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_full_out_valid", {31'd0, out_valid}, 32'd0);
    chk("flush_full_in_ready", {31'd0, in_ready}, 32'd1);
    out_ready = 1'b1;
    base = n_issued;
    step();
    step();
    chk("flush_full_nothing_issued", n_issued - base, 32'd0);

    // Flush with only main occupied: an accept in the flush cycle is discarded.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hBBBB0001;
    step();
    in_instr = 32'hCAFEF00D; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("flush_half_out_valid", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b1;
    step();
    chk("flush_half_still_empty", {31'd0, out_valid}, 32'd0);

`ifdef MIPS_DECODE_STATS_EN
    do_reset();
    chk_reset_state("stats_reset");
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_instr = 32'h00002000 + i;
      step();
    end
    in_valid = 1'b0; out_ready = 1'b0;
    step();
    step();
    step();
    chk("stat_accepted", {16'd0, stat_accepted}, 32'd5);
    chk("stat_stalls", {16'd0, stat_stalls}, 32'd3);
    out_ready = 1'b1;
    step();
    flush = 1'b1; in_valid = 1'b1; in_instr = 32'h0BADF00D;
    step();
    flush = 1'b0; in_valid = 1'b0;
    chk("stat_accepted_flush", {16'd0, stat_accepted}, 32'd5);
`else
    chk("stats_tied_zero", {stat_accepted, stat_stalls}, 32'd0);
`endif

    // Reset while stalled with a full buffer of all-ones words.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'hFFFFFFFF;
    step();
    step();
    in_valid = 1'b0;
    chk("pre_rst_full", {31'd0, in_ready}, 32'd0);
    do_reset();
    chk_reset_state("rst_in_stall");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
